// File: rtl/sine_note_detector.sv
// Loopback note detector: measures the period between rising midscale crossings of the synth
// waveform and reports the confirmed note one-hot. NOTE_DETECT_OCTAVE_LOW_EN adds 2x-period decode.
module sine_note_detector #(
  parameter int unsigned HYST    = 16,
  parameter int unsigned TOL     = 512,
  parameter int unsigned CONFIRM = 3,
  parameter int unsigned TIMEOUT = 200000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  sample_in,
  output logic [7:0]  note_onehot,
  output logic        note_valid,
  output logic [17:0] period_out,
  output logic        period_strobe,
  output logic        octave_low
);

  localparam int unsigned CW = 18;
  localparam int unsigned NN = 8;
  localparam logic [7:0]    LO        = 8'(128 - HYST);
  localparam logic [7:0]    HI        = 8'(128 + HYST);
  localparam logic [CW-1:0] CNT_MAX   = '1;
  localparam logic [CW-1:0] TIMEOUT_V = CW'(TIMEOUT);
  localparam logic [CW-1:0] TOL_V     = CW'(TOL);
  localparam logic [CW-1:0] TOL2_V    = CW'(2 * TOL);
  localparam logic [2:0]    CONFIRM_V = 3'(CONFIRM);

  typedef enum logic [1:0] {S_INIT, S_LOW, S_HIGH} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          have_ref;
  logic [2:0]    mcnt;
  logic [3:0]    cand;
  logic          edge_c;
  logic          hit_c;
  logic [3:0]    key_c;
  logic [2:0]    mcnt_inc_c;

  // Nominal note periods in 50 MHz clocks, 64*(L+1)
  function automatic logic [CW-1:0] nominal(input logic [2:0] i);
    case (i)
      3'd0:    return CW'(95616);
      3'd1:    return CW'(85184);
      3'd2:    return CW'(75904);
      3'd3:    return CW'(71680);
      3'd4:    return CW'(63872);
      3'd5:    return CW'(56896);
      3'd6:    return CW'(50688);
      default: return CW'(47872);
    endcase
  endfunction

  function automatic logic in_window(input logic [CW-1:0] p, input logic [CW-1:0] n,
                                     input logic [CW-1:0] t);
    return (p >= n - t) && (p <= n + t);
  endfunction

  assign edge_c     = (state == S_LOW) && (sample_in >= HI);
  assign mcnt_inc_c = (mcnt < CONFIRM_V) ? mcnt + 3'd1 : mcnt;

  // Period classification; key is {octave_low, note index}, base octave wins any overlap
  always_comb begin
    hit_c = 1'b0;
    key_c = '0;
`ifdef NOTE_DETECT_OCTAVE_LOW_EN
    for (int i = 0; i < NN; i++) begin
      if (in_window(period_out, nominal(3'(i)) << 1, TOL2_V)) begin
        hit_c = 1'b1;
        key_c = {1'b1, 3'(i)};
      end
    end
`endif
    for (int i = 0; i < NN; i++) begin
      if (in_window(period_out, nominal(3'(i)), TOL_V)) begin
        hit_c = 1'b1;
        key_c = {1'b0, 3'(i)};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_INIT;
      cnt           <= '0;
      have_ref      <= 1'b0;
      mcnt          <= '0;
      cand          <= '0;
      note_onehot   <= '0;
      note_valid    <= 1'b0;
      period_out    <= '0;
      period_strobe <= 1'b0;
      octave_low    <= 1'b0;
    end else begin
      period_strobe <= 1'b0;
      if (cnt != CNT_MAX) cnt <= cnt + CW'(1);

      case (state)
        S_INIT:  if (sample_in <= LO) state <= S_LOW;
        S_LOW:   if (sample_in >= HI) state <= S_HIGH;
        S_HIGH:  if (sample_in <= LO) state <= S_LOW;
        default: state <= S_INIT;
      endcase

      // A crossing takes priority over a coincident timeout
      if (edge_c) begin
        cnt      <= CW'(1);
        have_ref <= 1'b1;
        if (have_ref) begin
          period_out    <= cnt;
          period_strobe <= 1'b1;
        end
      end else if (cnt == TIMEOUT_V) begin
        note_onehot <= '0;
        note_valid  <= 1'b0;
        octave_low  <= 1'b0;
        mcnt        <= '0;
        have_ref    <= 1'b0;
      end

      if (period_strobe) begin
        if (hit_c && key_c == cand) begin
          mcnt <= mcnt_inc_c;
          if (mcnt_inc_c == CONFIRM_V) begin
            note_onehot <= 8'(1) << key_c[2:0];
            note_valid  <= 1'b1;
`ifdef NOTE_DETECT_OCTAVE_LOW_EN
            octave_low  <= key_c[3];
`else
            octave_low  <= 1'b0;
`endif
          end
        end else if (hit_c) begin
          cand <= key_c;
          mcnt <= 3'd1;
          if (CONFIRM_V == 3'd1) begin
            note_onehot <= 8'(1) << key_c[2:0];
            note_valid  <= 1'b1;
`ifdef NOTE_DETECT_OCTAVE_LOW_EN
            octave_low  <= key_c[3];
`else
            octave_low  <= 1'b0;
`endif
          end else begin
            note_onehot <= '0;
            note_valid  <= 1'b0;
            octave_low  <= 1'b0;
          end
        end else begin
          mcnt        <= '0;
          note_onehot <= '0;
          note_valid  <= 1'b0;
          octave_low  <= 1'b0;
        end
      end
    end
  end

endmodule
